// File: rtl/uart_mem_loader.sv
// Byte-stream memory loader/dumper: packs incoming UART bytes into 32-bit little-endian
// words and writes them to memory, or reads words back out as a byte stream.
module uart_mem_loader #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              load_start,
    input  logic              dump_start,
    input  logic [LEN_W-1:0]  dump_len,
    output logic [ADDR_W-1:0] address,
    output logic [3:0]        byteenable,
    output logic              chipselect,
    output logic              write,
    output logic [31:0]       writedata,
    input  logic [31:0]       readdata,
    output logic [7:0]        m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  word_count,
    output logic              overflow
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        WRITE   = 3'd2,
        RD      = 3'd3,
        RD_WAIT = 3'd4,
        TX      = 3'd5
    } state_t;

    localparam logic [LEN_W-1:0] WC_MAX = LEN_W'(2 ** ADDR_W);

    state_t            state, state_next;
    logic [ADDR_W-1:0] ptr;
    // Byte index within the current word; in WRITE it holds the number of filled lanes.
    logic [2:0]        lane;
    logic              last_seen;
    logic [31:0]       wbuf;
    logic [31:0]       rbuf;
    logic [LEN_W-1:0]  remain;
    logic [LEN_W-1:0]  wc;
    logic              ovf;
    logic              done_r;

    logic s_fire;
    logic m_fire;
    logic word_end;

    assign s_fire   = (state == LOAD) && s_valid;
    assign m_fire   = (state == TX) && m_ready;
    assign word_end = (lane == 3'd3) || s_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        s_ready    = 1'b0;
        chipselect = 1'b0;
        write      = 1'b0;
        byteenable = 4'b0000;
        m_valid    = 1'b0;
        m_data     = 8'h00;
        case (state)
            IDLE: begin
                if (load_start) begin
                    state_next = LOAD;
                end else if (dump_start && (dump_len != '0)) begin
                    state_next = RD;
                end
            end
            LOAD: begin
                s_ready = 1'b1;
                if (s_fire && word_end) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                chipselect = 1'b1;
                write      = 1'b1;
                case (lane)
                    3'd1:    byteenable = 4'b0001;
                    3'd2:    byteenable = 4'b0011;
                    3'd3:    byteenable = 4'b0111;
                    default: byteenable = 4'b1111;
                endcase
                state_next = last_seen ? IDLE : LOAD;
            end
            RD: begin
                chipselect = 1'b1;
                byteenable = 4'b1111;
                state_next = RD_WAIT;
            end
            RD_WAIT: begin
                state_next = TX;
            end
            TX: begin
                m_valid = 1'b1;
                m_data  = rbuf[{lane[1:0], 3'b000} +: 8];
                if (m_fire && (lane == 3'd3)) begin
                    state_next = (remain == '0) ? IDLE : RD;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr       <= '0;
            lane      <= '0;
            last_seen <= 1'b0;
            wbuf      <= '0;
            rbuf      <= '0;
            remain    <= '0;
            wc        <= '0;
            ovf       <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_start) begin
                        ptr       <= start_addr;
                        lane      <= '0;
                        wc        <= '0;
                        ovf       <= 1'b0;
                        wbuf      <= '0;
                        last_seen <= 1'b0;
                    end else if (dump_start) begin
                        if (dump_len == '0) begin
                            done_r <= 1'b1;
                        end else begin
                            ptr    <= start_addr;
                            remain <= dump_len;
                        end
                    end
                end
                LOAD: begin
                    if (s_fire) begin
                        wbuf[{lane[1:0], 3'b000} +: 8] <= s_data;
                        lane      <= lane + 3'd1;
                        last_seen <= s_last;
                    end
                end
                WRITE: begin
                    ptr  <= ptr + 1'b1;
                    lane <= '0;
                    // Cleared so a short final word has zeroed upper lanes.
                    wbuf <= '0;
                    if (ptr == '1) begin
                        ovf <= 1'b1;
                    end
                    if (wc != WC_MAX) begin
                        wc <= wc + 1'b1;
                    end
                    if (last_seen) begin
                        done_r <= 1'b1;
                    end
                end
                RD_WAIT: begin
                    rbuf   <= readdata;
                    ptr    <= ptr + 1'b1;
                    remain <= remain - 1'b1;
                    lane   <= '0;
                end
                TX: begin
                    if (m_fire) begin
                        if (lane == 3'd3) begin
                            if (remain == '0) begin
                                done_r <= 1'b1;
                            end
                        end else begin
                            lane <= lane + 3'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign address    = ptr;
    assign writedata  = wbuf;
    assign busy       = (state != IDLE);
    assign done       = done_r;
    assign word_count = wc;
    assign overflow   = ovf;

endmodule
